// File: rtl/divider_pkg.sv
// Shared definitions for the pixel-path clock divider controller:
// FSM state type, default settings and the request validity rule.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NREQ_VAL = 2;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_DIV_VAL  = 5;
    localparam int DEF_HI_VAL   = 2;

    // A setting is usable when the period has at least two cycles and the
    // output spends at least one cycle high and at least one cycle low.
    // Callers zero-extend their CNT_W fields, so the compare stays unsigned.
    function automatic logic settings_valid(input logic [31:0] div,
                                            input logic [31:0] hi);
        return (div >= 32'd2) && (hi >= 32'd1) && (hi < div);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester granted last drops to lowest priority
// once the grant is consumed (advance). Priority starts at requester 0.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic              advance,
    output logic [NREQ-1:0]   grant,
    output logic [IDX_W-1:0]  idx
);

    // ptr names the requester with the highest priority for the next grant
    logic [IDX_W-1:0] ptr;
    logic             found;

    // Search from ptr upwards first, then wrap around from requester 0
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (IDX_W'(j) >= ptr)) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

    // Move priority to the requester after the one just granted
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            if (idx == IDX_W'(NREQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/divider_sched.sv
// Pixel-path clock divider controller. Owns the period counter and the
// divisor/high-time registers, and applies arbitrated change requests only
// at a period boundary so clk_out never shows a runt or stretched phase.
module divider_sched
    import divider_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ_VAL,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = DEF_DIV_VAL,
    parameter int DEF_HI  = DEF_HI_VAL
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   req_div,
    input  logic [NREQ*CNT_W-1:0]   req_hi,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         nack,
    output logic                    busy,
    output logic                    clk_out,
    output logic                    clk_en,
    output logic [CNT_W-1:0]        cur_div,
    output logic [CNT_W-1:0]        cur_hi
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   last_cnt;
    logic               at_end;
    logic [CNT_W-1:0]   sel_div;
    logic [CNT_W-1:0]   sel_hi;
    logic [CNT_W-1:0]   lat_div;
    logic [CNT_W-1:0]   lat_hi;
    logic [IDX_W-1:0]   lat_idx;
    logic               lat_valid;
    logic [NREQ-1:0]    gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               advance;
    logic               apply;

    // cur_div is always >= 2, so cur_div-1 never wraps
    assign last_cnt  = cur_div - CNT_W'(1);
    assign at_end    = (cnt == last_cnt);
    assign advance   = (state == IDLE) && (|req);
    assign apply     = (state == WAIT) && at_end;
    assign lat_valid = settings_valid(32'(lat_div), 32'(lat_hi));
    assign busy      = (state != IDLE);

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .grant   (gnt),
        .idx     (gnt_idx)
    );

    // Pick the granted requester's fields through the one-hot grant
    always_comb begin
        sel_div = '0;
        sel_hi  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_div = sel_div | req_div[i*CNT_W +: CNT_W];
                sel_hi  = sel_hi  | req_hi[i*CNT_W +: CNT_W];
            end
        end
    end

    // Period counter: 0..cur_div-1, restarting at 0 on the boundary edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Settings in force change only on the boundary edge while a request waits
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_div <= CNT_W'(DEF_DIV);
            cur_hi  <= CNT_W'(DEF_HI);
        end else if (apply) begin
            cur_div <= lat_div;
            cur_hi  <= lat_hi;
        end
    end

    // Registered waveform and period-start enable derived from the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_out <= 1'b0;
            clk_en  <= 1'b0;
        end else begin
            clk_out <= (cnt < cur_hi);
            clk_en  <= (cnt == '0);
        end
    end

    // Request sequencing: grant and latch, validate, wait for boundary, settle
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_idx <= '0;
            lat_div <= '0;
            lat_hi  <= '0;
            ack     <= '0;
            nack    <= '0;
        end else begin
            ack  <= '0;
            nack <= '0;
            case (state)
                IDLE: begin
                    if (advance) begin
                        lat_idx <= gnt_idx;
                        lat_div <= sel_div;
                        lat_hi  <= sel_hi;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (!lat_valid) begin
                        for (int i = 0; i < NREQ; i++) begin
                            nack[i] <= (lat_idx == IDX_W'(i));
                        end
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (at_end) begin
                        for (int i = 0; i < NREQ; i++) begin
                            ack[i] <= (lat_idx == IDX_W'(i));
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_sched.sv
// Self-checking bench for divider_sched: transaction-level reference model,
// expected-response queue and an independent monitor.
module tb_divider_sched;

    localparam int NREQ  = 2;
    localparam int CNT_W = 16;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*CNT_W-1:0]   req_div;
    logic [NREQ*CNT_W-1:0]   req_hi;
    logic [NREQ-1:0]         ack;
    logic [NREQ-1:0]         nack;
    logic                    busy;
    logic                    clk_out;
    logic                    clk_en;
    logic [CNT_W-1:0]        cur_div;
    logic [CNT_W-1:0]        cur_hi;

    logic [CNT_W-1:0] div_arr [NREQ];
    logic [CNT_W-1:0] hi_arr  [NREQ];

    always_comb begin
        req_div = '0;
        req_hi  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_div[i*CNT_W +: CNT_W] = div_arr[i];
            req_hi[i*CNT_W +: CNT_W]  = hi_arr[i];
        end
    end

    divider_sched #(
        .NREQ    (NREQ),
        .CNT_W   (CNT_W),
        .DEF_DIV (5),
        .DEF_HI  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_div (req_div),
        .req_hi  (req_hi),
        .ack     (ack),
        .nack    (nack),
        .busy    (busy),
        .clk_out (clk_out),
        .clk_en  (clk_en),
        .cur_div (cur_div),
        .cur_hi  (cur_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              edge_no;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] nack;
    } resp_t;

    resp_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input longint act, input longint req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req_v);
        end
    endtask

    // ---------------- reference model ----------------
    // Position within the current period, settings in force, and at most one
    // outstanding transaction described by its grant edge.
    int edge_cnt = 0;
    bit model_ready = 1'b0;
    int m_pos, m_div, m_hi, m_last, m_free, m_gedge, m_idx, m_ldiv, m_lhi;
    bit m_active, m_valid;
    bit exp_out, exp_en, exp_busy;

    always @(posedge clk) begin : model
        resp_t r;
        bit    boundary;
        bit    found;
        int    c;
        edge_cnt++;
        if (reset) begin
            m_pos = 0; m_div = 5; m_hi = 2; m_last = -1; m_free = 0;
            m_active = 1'b0; m_valid = 1'b0;
            exp_out = 1'b0; exp_en = 1'b0; exp_busy = 1'b0;
            exp_q.delete();
            model_ready = 1'b1;
        end else begin
            boundary = (m_pos == m_div - 1);
            exp_out  = (m_pos < m_hi);
            exp_en   = (m_pos == 0);
            if (m_active && m_valid && boundary && (edge_cnt >= m_gedge + 2)) begin
                r.edge_no = edge_cnt; r.ack = '0; r.nack = '0; r.ack[m_idx] = 1'b1;
                exp_q.push_back(r);
                m_div = m_ldiv; m_hi = m_lhi;
                m_active = 1'b0; m_free = edge_cnt + 2;
            end else if (m_active && !m_valid && (edge_cnt == m_gedge + 1)) begin
                r.edge_no = edge_cnt; r.ack = '0; r.nack = '0; r.nack[m_idx] = 1'b1;
                exp_q.push_back(r);
                m_active = 1'b0; m_free = edge_cnt + 2;
            end else if (!m_active && (edge_cnt >= m_free) && (req != '0)) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_idx = c;
                    end
                end
                m_last   = m_idx;
                m_ldiv   = int'(div_arr[m_idx]);
                m_lhi    = int'(hi_arr[m_idx]);
                m_valid  = (m_ldiv >= 2) && (m_lhi >= 1) && (m_lhi <= m_ldiv - 1);
                m_active = 1'b1;
                m_gedge  = edge_cnt;
            end
            m_pos    = boundary ? 0 : m_pos + 1;
            exp_busy = m_active || (edge_cnt < m_free - 1);
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        resp_t r;
        if (model_ready) begin
            check("clk_out", clk_out, exp_out);
            check("clk_en", clk_en, exp_en);
            check("busy", busy, exp_busy);
            check("cur_div", cur_div, m_div);
            check("cur_hi", cur_hi, m_hi);
            if (((ack | nack) != '0) || (exp_q.size() > 0 && exp_q[0].edge_no == edge_cnt)) begin
                if (exp_q.size() == 0 || exp_q[0].edge_no != edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_timing at t=%0t: got ack=%b nack=%b, none expected this cycle",
                             $time, ack, nack);
                end else begin
                    r = exp_q.pop_front();
                    check("ack", ack, r.ack);
                    check("nack", nack, r.nack);
                end
            end
        end
    end

    // ---------------- requester ----------------
    task automatic do_req(input int i, input int d, input int h, input bit scramble);
        int n;
        bit done;
        @(negedge clk);
        div_arr[i] = CNT_W'(d);
        hi_arr[i]  = CNT_W'(h);
        req[i]     = 1'b1;
        done = 1'b0;
        n    = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (ack[i] || nack[i]) begin
                done = 1'b1;
            end else if (scramble && n == 2) begin
                div_arr[i] = CNT_W'(7);
            end
        end
        req[i] = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL req%0d_timeout: got no ack/nack after %0d cycles, expected one", i, n);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int mask, d0, h0, d1, h1;
        for (int i = 0; i < NREQ; i++) begin
            div_arr[i] = '0;
            hi_arr[i]  = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle_cycles(12);

        // shorten period to 4/2 on a boundary
        do_req(0, 4, 2, 1'b0);
        idle_cycles(10);
        // invalid request rejected, settings unchanged
        do_req(1, 1, 0, 1'b0);
        idle_cycles(6);
        // two simultaneous pairs: requester 0 served first both times
        fork
            do_req(0, 6, 3, 1'b0);
            do_req(1, 2, 1, 1'b0);
        join
        idle_cycles(4);
        fork
            do_req(0, 6, 3, 1'b0);
            do_req(1, 2, 1, 1'b0);
        join
        idle_cycles(6);
        check("pair_final_div", cur_div, 2);
        check("pair_final_hi", cur_hi, 1);

        // reset while a request waits for a long period to finish
        do_req(0, 9, 4, 1'b0);
        @(negedge clk);
        div_arr[0] = CNT_W'(3);
        hi_arr[0]  = CNT_W'(1);
        req[0]     = 1'b1;
        idle_cycles(3);
        check("busy_in_wait", busy, 1);
        reset  = 1'b1;
        req[0] = 1'b0;
        idle_cycles(2);
        reset = 1'b0;
        idle_cycles(1);
        check("reset_div", cur_div, 5);
        check("reset_hi", cur_hi, 2);
        idle_cycles(10);

        // data changed after grant is ignored
        do_req(0, 3, 2, 1'b1);
        idle_cycles(6);
        check("latched_div", cur_div, 3);
        check("latched_hi", cur_hi, 2);

        // random traffic, mix of valid and invalid settings
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(3, 1);
            d0 = $urandom_range(11, 0);
            h0 = $urandom_range(d0 + 1, 0);
            d1 = $urandom_range(11, 0);
            h1 = $urandom_range(d1 + 1, 0);
            fork
                begin
                    if (mask[0]) do_req(0, d0, h0, 1'b0);
                end
                begin
                    if (mask[1]) do_req(1, d1, h1, 1'b0);
                end
            join
            idle_cycles($urandom_range(5, 0));
        end

        idle_cycles(20);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider_sched.md
# divider_sched

Runtime controller for the pixel-path clock divider. It arbitrates divisor/high-time change requests from up to NREQ image-pipeline requesters and owns the period counter. New settings are applied only at a period boundary, so the divided output never produces a runt or stretched phase. It also emits the divided waveform and a one-cycle period-start enable for downstream stages.

## Interface
- NREQ, 2, number of requesters (1..8)
- CNT_W, 16, width of the counter, divisor and high-time fields
- DEF_DIV, 5, divisor loaded at reset (period in clk cycles)
- DEF_HI, 2, high-time loaded at reset (cycles clk_out is 1 per period)
- clk  input  1  sole clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  level request per requester; held until its ack or nack
- req_div  input  NREQ*CNT_W  requested divisor; requester i uses slice [i*CNT_W +: CNT_W]
- req_hi  input  NREQ*CNT_W  requested high-time, sliced the same way
- ack  output  NREQ  one-cycle pulse: request applied
- nack  output  NREQ  one-cycle pulse: request rejected as invalid
- busy  output  1  FSM not in IDLE
- clk_out  output  1  registered divided waveform
- clk_en  output  1  registered one-cycle pulse at each period start
- cur_div  output  CNT_W  divisor currently in force
- cur_hi  output  CNT_W  high-time currently in force

## Operation
- Counter cnt runs 0..cur_div-1 and then wraps to 0.
- Every cycle out of reset: clk_out <= (cnt < cur_hi); clk_en <= (cnt == 0).
- Valid request: req_div >= 2 and 1 <= req_hi <= req_div-1. All comparisons are unsigned CNT_W.
- FSM states:
  - IDLE: if any req bit is set, the round-robin arbiter grants one. Latch its index, req_div and req_hi, then go to CHECK.
  - CHECK: if the latched request is invalid, pulse nack[idx] and go to DONE. Otherwise go to WAIT.
  - WAIT: on the edge where cnt == cur_div-1, load cnt<=0, cur_div and cur_hi from the latched values, pulse ack[idx], and go to DONE.
  - DONE: one cycle with req ignored, then IDLE. This gives the requester time to drop req after seeing ack/nack.
- Round-robin: the requester granted last has the lowest priority on the next grant. After reset, priority order is 0 first.
- Request data is latched at grant. Changes on req_div/req_hi or a dropped req during CHECK/WAIT have no effect.
- Reset, including mid-CHECK or mid-WAIT: cnt=0, cur_div=DEF_DIV, cur_hi=DEF_HI, clk_out=0, clk_en=0, ack=0, nack=0, busy=0, state IDLE, RR pointer at 0. Any pending request is discarded with no ack or nack.

## Timing
- Grant-to-nack: req seen in IDLE at edge N; nack is high for the cycle after edge N+1.
- Grant-to-ack: at least 2 edges, plus waiting for the current period to finish. Worst case is cur_div+1 edges after entering WAIT.
- The first period with new settings starts on the edge that pulses ack. clk_en and clk_out reflect it one edge later, because both outputs are registered.
- A period in progress is never truncated or extended.
- Simultaneous reqs: one grant per IDLE visit, so at most one ack or nack per 3+ cycles. Others wait with req held.
- If the latched settings equal the current ones, the request is still applied at the boundary and acked.
- busy is high from the edge that leaves IDLE through the DONE cycle.

## Structure
- Shared package divider_pkg holds:
  - state enum {IDLE, CHECK, WAIT, DONE}
  - default parameter constants
  - validity-check function
- Sub-module rr_arbiter (NREQ-wide):
  - inputs: req vector, advance strobe
  - outputs: one-hot grant, grant index
- The counter, the configuration registers and the FSM live in divider_sched.

## Test plan
- Reset, DEF 5/2 -> clk_out repeats 1,1,0,0,0; clk_en pulses every 5 cycles; cur_div=5, cur_hi=2.
- req0 with div=4, hi=2, raised while cnt=1 -> ack0 exactly at the period boundary. The old period completes (1,1,0,0,0), then 1,1,0,0 repeats with no runt.
- req1 with div=1, hi=0 -> nack1 two edges after grant; cur_div/cur_hi unchanged; waveform undisturbed.
- req0 (div=6, hi=3) and req1 (div=2, hi=1) raised together -> req0 acked first, then req1. Next simultaneous pair is served req0 first again, because the pointer has passed 1. Final waveform is 1,0 repeating.
- Reset asserted during WAIT -> no ack; defaults restored; 1,1,0,0,0 resumes from cnt=0.
- div=3, hi=2 request, with req_div changed to 7 after grant -> applied value is 3; clk_out repeats 1,1,0.
